// File: rtl/ila_trigger_ctrl.sv
// Capture sequencer and trigger unit for the ILA: walks the sample RAM write pointer through
// prefill, armed, post-trigger and done, and exposes control/status registers on the CPU bus.
module ila_trigger_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic [31:0]      bus_addr,
    input  logic             bus_wen,
    input  logic             bus_ren,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             cap_we,
    output logic [AW-1:0]    cap_addr,
    output logic             trigger_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PREFILL = 3'd1,
        S_ARMED   = 3'd2,
        S_POST    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t           state, state_n;
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    pcnt;
    logic [AW-1:0]    post_cnt;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] value;
    logic [AW-1:0]    post_len;
    logic [AW-1:0]    trig_idx;
    logic             mode;
    logic             triggered;
    logic             force_pend;
    logic             prev_match;

    logic [2:0]    word;
    logic          ctrl_wr, arm, abort, force_wr;
    logic          cfg_ok, capturing, enter_prefill;
    logic          match, hit, fire, done;
    logic [AW-1:0] pre_thr;
    logic [AW:0]   pcnt_next;
    logic          pre_done;
    logic          unused_bits;

    assign word     = bus_addr[4:2];
    assign ctrl_wr  = bus_wen && (word == 3'd0);
    assign arm      = ctrl_wr && bus_wdata[0];
    assign abort    = ctrl_wr && bus_wdata[1];
    assign force_wr = ctrl_wr && bus_wdata[2];

    assign cfg_ok    = (state == S_IDLE) || (state == S_DONE);
    assign capturing = (state == S_PREFILL) || (state == S_ARMED) || (state == S_POST);
    assign done      = (state == S_DONE);
    // ABORT beats a simultaneous ARM
    assign enter_prefill = cfg_ok && arm && !abort;

    assign match = ((sample_in & mask) == (value & mask));
    assign hit   = mode ? (match && !prev_match) : match;
    assign fire  = (state == S_ARMED) && (hit || force_pend) && !abort;

    // Threshold 0 still takes one prefill sample, so compare count+1 against it
    assign pre_thr   = LAST_IDX - post_len;
    assign pcnt_next = {1'b0, pcnt} + (AW+1)'(1);
    assign pre_done  = (pcnt_next >= {1'b0, pre_thr});

    assign cap_we      = capturing;
    assign cap_addr    = wptr;
    assign trigger_out = fire;

    assign unused_bits = ^{bus_addr[31:5], bus_addr[1:0], bus_ren, bus_wdata};

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (arm) state_n = S_PREFILL;
            S_PREFILL: if (pre_done) state_n = S_ARMED;
            S_ARMED:   if (fire) state_n = (post_len == '0) ? S_DONE : S_POST;
            S_POST:    if (post_cnt == AW'(1)) state_n = S_DONE;
            S_DONE:    if (arm) state_n = S_PREFILL;
            default:   state_n = S_IDLE;
        endcase
        if (abort) state_n = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr       <= '0;
            pcnt       <= '0;
            post_cnt   <= '0;
            trig_idx   <= '0;
            triggered  <= 1'b0;
            force_pend <= 1'b0;
            prev_match <= 1'b0;
        end else begin
            if (enter_prefill) begin
                wptr <= '0;
                pcnt <= '0;
            end else begin
                if (capturing) wptr <= wptr + AW'(1);
                if (state == S_PREFILL) pcnt <= pcnt + AW'(1);
            end

            if (enter_prefill) prev_match <= 1'b0;
            else if (capturing) prev_match <= match;

            if (fire) begin
                post_cnt <= post_len;
                trig_idx <= wptr;
            end else if (state == S_POST) begin
                post_cnt <= post_cnt - AW'(1);
            end

            if (abort || enter_prefill) triggered <= 1'b0;
            else if (fire) triggered <= 1'b1;

            // FORCE is only remembered while a capture is in flight
            if (abort || enter_prefill) force_pend <= 1'b0;
            else if (force_wr && capturing) force_pend <= 1'b1;
            else if (fire) force_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mask     <= '0;
            value    <= '0;
            post_len <= '0;
            mode     <= 1'b0;
        end else if (bus_wen && cfg_ok) begin
            case (word)
                3'd2:    mask     <= bus_wdata[WIDTH-1:0];
                3'd3:    value    <= bus_wdata[WIDTH-1:0];
                3'd4:    post_len <= bus_wdata[AW-1:0];
                3'd6:    mode     <= bus_wdata[0];
                default: ;
            endcase
        end
    end

    always_comb begin
        bus_rdata = '0;
        case (word)
            3'd1:    bus_rdata = {27'd0, triggered, done, state};
            3'd2:    bus_rdata[WIDTH-1:0] = mask;
            3'd3:    bus_rdata[WIDTH-1:0] = value;
            3'd4:    bus_rdata[AW-1:0] = post_len;
            3'd5:    bus_rdata[AW-1:0] = trig_idx;
            3'd6:    bus_rdata[0] = mode;
            default: bus_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_ila_trigger_ctrl.sv
// Directed bench for ila_trigger_ctrl with WIDTH=8, DEPTH=16: level/edge triggers, FORCE,
// ABORT, async reset and pointer wrap-around, checked against hand-computed values.
module tb_ila_trigger_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] sample_in;
    logic [31:0]      bus_addr;
    logic             bus_wen;
    logic             bus_ren;
    logic [31:0]      bus_wdata;
    logic [31:0]      bus_rdata;
    logic             cap_we;
    logic [AW-1:0]    cap_addr;
    logic             trigger_out;

    ila_trigger_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .sample_in(sample_in),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .cap_we(cap_we), .cap_addr(cap_addr), .trigger_out(trigger_out)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_we, n_trig, n_pre, n_post;
    logic [AW-1:0]    last_addr, trig_addr;
    logic [WIDTH-1:0] trig_sample;
    logic             ramp;
    logic [WIDTH-1:0] hold;
    logic [31:0]      rv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_we = 0; n_trig = 0; n_pre = 0; n_post = 0;
        last_addr = '0; trig_addr = '0; trig_sample = '0;
    endtask

    // Called with bus_addr = STATUS, after inputs for this cycle are settled
    task automatic observe();
        if (cap_we === 1'b1) begin
            n_we++;
            last_addr = cap_addr;
            if (bus_rdata[2:0] == 3'd1) n_pre++;
            if (bus_rdata[2:0] == 3'd3) n_post++;
        end
        if (trigger_out === 1'b1) begin
            n_trig++;
            trig_addr   = cap_addr;
            trig_sample = sample_in;
        end
    endtask

    task automatic step();
        @(negedge clk);
        bus_wen   = 1'b0;
        bus_addr  = 32'h4;
        bus_wdata = '0;
        sample_in = ramp ? sample_in + 1'b1 : hold;
        #1;
        observe();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_addr  = a;
        bus_wdata = d;
        bus_wen   = 1'b1;
        step();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus_addr = a;
        #1;
        d = bus_rdata;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (bus_rdata[2:0] != 3'd4 && k < bound) begin
            step();
            k++;
        end
        chk("reach_done", {29'd0, bus_rdata[2:0]}, 32'd4);
    endtask

    initial begin
        rst = 1'b1; bus_addr = 32'h4; bus_wen = 1'b0; bus_ren = 1'b0; bus_wdata = '0;
        sample_in = '0; hold = '0; ramp = 1'b0;
        clr();
        #25;
        chk("rst_cap_we", {31'd0, cap_we}, 32'd0);
        chk("rst_cap_addr", {28'd0, cap_addr}, 32'd0);
        chk("rst_trigger", {31'd0, trigger_out}, 32'd0);
        rd(32'h04, rv); chk("rst_status", rv, 32'd0);
        rd(32'h08, rv); chk("rst_mask", rv, 32'd0);
        rd(32'h10, rv); chk("rst_post", rv, 32'd0);
        rd(32'h14, rv); chk("rst_trig_idx", rv, 32'd0);
        rd(32'h18, rv); chk("rst_mode", rv, 32'd0);
        rst = 1'b0;
        step();

        // Level trigger on a ramp
        wr(32'h08, 32'hFF); wr(32'h0C, 32'h5A); wr(32'h10, 32'd4); wr(32'h18, 32'd0);
        rd(32'h0C, rv); chk("value_rb", rv, 32'h5A);
        rd(32'h00, rv); chk("ctrl_reads0", rv, 32'd0);
        clr(); hold = '0; ramp = 1'b0;
        wr(32'h00, 32'd1);
        chk("arm_first_we", {31'd0, cap_we}, 32'd1);
        chk("arm_first_addr", {28'd0, cap_addr}, 32'd0);
        ramp = 1'b1;
        wait_done(200);
        ramp = 1'b0;
        chk("lvl_prefill_writes", n_pre, 32'd11);
        chk("lvl_trig_count", n_trig, 32'd1);
        chk("lvl_trig_sample", {24'd0, trig_sample}, 32'h5A);
        chk("lvl_trig_addr", {28'd0, trig_addr}, 32'd10);
        chk("lvl_post_writes", n_post, 32'd4);
        chk("lvl_total_writes", n_we, 32'd95);
        chk("lvl_last_addr", {28'd0, last_addr}, 32'd14);
        chk("lvl_done_we", {31'd0, cap_we}, 32'd0);
        chk("lvl_status", bus_rdata, 32'h1C);
        rd(32'h14, rv); chk("lvl_trig_idx", rv, 32'd10);

        // Rising-edge trigger with the probe held at the match value
        hold = 8'h5A;
        wr(32'h18, 32'd1);
        clr();
        wr(32'h00, 32'd1);
        chk("edge_rearm_status", bus_rdata, 32'd1);
        repeat (14) step();
        chk("edge_no_trig", n_trig, 32'd0);
        chk("edge_armed_status", bus_rdata, 32'd2);
        chk("edge_prefill_writes", n_pre, 32'd11);
        hold = 8'h00;
        step(); step();
        hold = 8'h5A;
        step();
        chk("edge_pulse", {31'd0, trigger_out}, 32'd1);
        wait_done(20);
        chk("edge_trig_count", n_trig, 32'd1);
        chk("edge_status", bus_rdata, 32'h1C);
        rd(32'h14, rv); chk("edge_trig_idx", rv, 32'd1);

        // FORCE during prefill with POST = 0
        hold = 8'h00;
        wr(32'h18, 32'd0); wr(32'h10, 32'd0);
        clr();
        wr(32'h00, 32'd1);
        step(); step();
        wr(32'h00, 32'd4);
        wait_done(40);
        chk("force_total_writes", n_we, 32'd16);
        chk("force_prefill_writes", n_pre, 32'd15);
        chk("force_trig_count", n_trig, 32'd1);
        chk("force_trig_addr", {28'd0, trig_addr}, 32'd15);
        chk("force_post_writes", n_post, 32'd0);
        chk("force_status", bus_rdata, 32'h1C);
        rd(32'h14, rv); chk("force_trig_idx", rv, 32'd15);

        // ABORT (with ARM) in the middle of POST
        wr(32'h08, 32'd0); wr(32'h10, 32'd4);
        clr();
        wr(32'h00, 32'd1);
        repeat (10) step();
        step();
        chk("mask0_trigger", {31'd0, trigger_out}, 32'd1);
        step(); step();
        chk("post_status", bus_rdata, 32'h13);
        wr(32'h00, 32'd3);
        chk("abort_we", {31'd0, cap_we}, 32'd0);
        chk("abort_status", bus_rdata, 32'd0);
        rd(32'h14, rv); chk("abort_trig_idx", rv, 32'd11);
        wr(32'h10, 32'd7);
        rd(32'h10, rv); chk("post_wr_idle", rv, 32'd7);
        wr(32'h08, 32'hFF);
        clr();
        wr(32'h00, 32'd1);
        repeat (8) step();
        chk("armed7_status", bus_rdata, 32'd2);
        wr(32'h00, 32'd1);
        chk("arm_ignored_armed", bus_rdata, 32'd2);
        wr(32'h10, 32'd2);
        rd(32'h10, rv); chk("post_wr_armed", rv, 32'd7);

        // Asynchronous reset between clock edges while ARMED
        #3;
        rst = 1'b1;
        #1;
        chk("arst_cap_we", {31'd0, cap_we}, 32'd0);
        chk("arst_cap_addr", {28'd0, cap_addr}, 32'd0);
        chk("arst_trigger", {31'd0, trigger_out}, 32'd0);
        rd(32'h04, rv); chk("arst_status", rv, 32'd0);
        rd(32'h10, rv); chk("arst_post", rv, 32'd0);
        step(); step();
        rst = 1'b0;
        clr();
        repeat (5) step();
        chk("arst_no_capture", n_we, 32'd0);

        // Wrap-around: POST = DEPTH-1, trigger at wptr 3
        wr(32'h08, 32'hFF); wr(32'h0C, 32'h03); wr(32'h10, 32'd15);
        clr(); hold = '0; ramp = 1'b0;
        wr(32'h00, 32'd1);
        ramp = 1'b1;
        wait_done(60);
        ramp = 1'b0;
        chk("wrap_prefill_writes", n_pre, 32'd1);
        chk("wrap_trig_addr", {28'd0, trig_addr}, 32'd3);
        chk("wrap_trig_sample", {24'd0, trig_sample}, 32'd3);
        chk("wrap_post_writes", n_post, 32'd15);
        chk("wrap_last_addr", {28'd0, last_addr}, 32'd2);
        chk("wrap_total_writes", n_we, 32'd19);
        chk("wrap_status", bus_rdata, 32'h1C);
        rd(32'h14, rv); chk("wrap_trig_idx", rv, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ila_trigger_ctrl.md
# ila_trigger_ctrl

Capture sequencer and trigger unit for the integrated logic analyzer. Owns the arm/prefill/wait/post-trigger/done sequence, evaluates a masked value or edge trigger on the probe bus, and drives write-enable and write-address of the ILA sample RAM. Sits between the CPU bus and the sample RAM. Readout of RAM contents stays with the existing ILA read path.

## Interface
Parameters:
- WIDTH, 32: probe width in bits, 1..32.
- DEPTH, 1024: sample RAM depth, power of two ≥ 4. AW = $clog2(DEPTH).

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- sample_in  in  WIDTH  probe bus, sampled every clk.
- bus_addr  in  32  byte address; block decodes bus_addr[4:2], ignores the rest.
- bus_wen  in  1  write strobe, one cycle per write.
- bus_ren  in  1  read strobe; rdata does not depend on it.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  combinational read data.
- cap_we  out  1  RAM write enable.
- cap_addr  out  AW  RAM write address.
- trigger_out  out  1  one-cycle pulse in the cycle the trigger sample is written.

## Operation
- Registers, by word index bus_addr[4:2]:
  - 0 CTRL, write-only, reads 0. Bit0 ARM, bit1 ABORT, bit2 FORCE.
  - 1 STATUS. [2:0] state, bit3 done, bit4 triggered.
  - 2 TRIG_MASK, WIDTH bits.
  - 3 TRIG_VALUE, WIDTH bits.
  - 4 POST, AW bits.
  - 5 TRIG_IDX, AW bits, read-only.
  - 6 MODE, bit0: 0 = level, 1 = rising edge.
  - 7 reads 0.
- Read data is zero-extended to 32 bits.
- Writes to MASK/VALUE/POST/MODE are ignored unless state is IDLE or DONE.
- Match condition: (sample_in & MASK) == (VALUE & MASK). MASK = 0 matches always.
- Edge mode: match this cycle and no match on the previous captured sample. The previous-match flag clears on entering PREFILL.
- States and transitions:
  - IDLE (0): cap_we = 0. ARM → PREFILL; wptr and prefill count are set to 0.
  - PREFILL (1): cap_we = 1, wptr increments and wraps mod DEPTH. When prefill count reaches DEPTH-1-POST → ARMED. With POST = DEPTH-1 the threshold is 0, so the block goes to ARMED after one sample. Triggers are ignored in PREFILL.
  - ARMED (2): cap_we = 1. On match or pending FORCE, the current sample becomes the trigger sample:
    - TRIG_IDX ← wptr, trigger_out = 1, triggered = 1.
    - Post counter ← POST.
    - If POST = 0 → DONE, else → POST.
  - POST (3): cap_we = 1. Counter decrements on each written sample. The sample written with counter = 1 is the last one, then → DONE. Total post-trigger samples = POST.
  - DONE (4): cap_we = 0, done = 1. ARM → PREFILL, which clears done and triggered.
- ABORT in any state → IDLE next cycle. done and triggered are cleared; TRIG_IDX keeps its value.
- FORCE sets a pending flag, which is consumed on the first ARMED cycle. A FORCE write in IDLE or DONE is dropped.
- Simultaneous bits: if ABORT and ARM are written together, ABORT wins. ARM while in PREFILL, ARMED or POST is ignored.
- Oldest valid sample after DONE is at TRIG_IDX - (DEPTH-1-POST), mod DEPTH. Software recovers it from TRIG_IDX.

## Timing
- Reset values:
  - State IDLE; cap_we 0, cap_addr 0, trigger_out 0.
  - MASK 0, VALUE 0, POST 0, MODE 0, TRIG_IDX 0, done 0, triggered 0.
- A CTRL write in cycle N changes state at the edge ending N. The first cap_we = 1 is in cycle N+1 with cap_addr = 0.
- cap_addr = wptr. When cap_we = 1, the RAM writes sample_in at (clk, cap_addr). Match uses the same-cycle sample_in, so trigger latency is zero.
- Bus reads are combinational and reflect register state before any same-cycle write.
- Capture length from trigger: trigger sample plus POST samples. cap_we drops in the cycle after the last post sample.

## Test plan
- DEPTH=16, MASK=0xFF, VALUE=0x5A, POST=4, level mode. Arm, ramp sample_in from 0. Expect:
  - 11 prefill writes, then ARMED.
  - trigger_out when sample = 0x5A, TRIG_IDX = (0x5A mod 16) = 10.
  - 4 more writes, STATUS = 0x1C (DONE + done + triggered).
- Edge mode, sample_in held at 0x5A through arm and prefill → no trigger. Drop to 0 then return to 0x5A → single trigger_out pulse.
- POST=0 with FORCE written during PREFILL. Expect:
  - Trigger on the first ARMED cycle (wptr = 15 for DEPTH=16).
  - DONE next cycle, exactly 16 writes total.
- ABORT mid-POST → IDLE next cycle, cap_we 0, STATUS = 0. Writing POST afterwards takes effect; writing POST while ARMED reads back unchanged.
- Assert rst asynchronously mid-ARMED, between clock edges. Expect all outputs at reset values immediately, with no further cap_we until ARM.
- Wrap-around: DEPTH=16, POST=15. ARMED is reached after 1 sample. Trigger at wptr 3, capture continues across 15→0, done after 15 post writes with last cap_addr = 2.
